rr_encoder_arbiter: RTL
=======================

// Module: rr_encoder_arbiter
// PURPOSE
//  Round-robin arbiter sharing one downstream resource among 4 one-hot requesters.
//  Extends the 4-to-2 encoder with state: it selects one winner, holds the grant until
//  release, and reports the winner both one-hot and as a 2-bit encoded index.
//  It sits between the request lines and the encoded-index consumer.
// PARAMETERS
//  N         4   number of requesters; fixed at 4 in this revision
//  IDX_W     2   encoded index width, equal to clog2(N)
//  MAX_HOLD  8   maximum cycles a grant is held before forced release; legal range 2..255
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  en         in   1      1 = arbitration enabled; 0 = no new grants are issued
//  req        in   N      request vector; req[i]=1 means requester i wants the resource
//  done       in   1      the current owner releases the resource (1-cycle pulse)
//  gnt        out  N      one-hot grant; all zeros when idle
//  gnt_idx    out  IDX_W  encoded index of the owner; valid only while gnt_valid=1
//  gnt_valid  out  1      a grant is active
//  timeout    out  1      1-cycle pulse when a grant is force-released at MAX_HOLD
// BEHAVIOUR
//  Reset (async, any time): gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0,
//   hold_cnt=0, state=IDLE. A reset mid-grant drops the grant immediately.
//  All outputs are registered.
//  State machine: IDLE, GRANT.
//  IDLE:
//   - If en=1 and |req, the winner is the first set bit of req, scanning from ptr
//     upward with wrap (ptr, ptr+1, ..., ptr+3 mod 4).
//   - Next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0,
//     state=GRANT. Request-to-grant latency is 1 cycle.
//   - If en=0 or req=0: the block stays in IDLE and all outputs stay 0.
//  GRANT (owner = gnt_idx), per cycle:
//   - hold_cnt increments each cycle.
//   - Release when done=1, or req[owner]=0, or hold_cnt==MAX_HOLD-1.
//   - On release: next edge gnt=0, gnt_valid=0, ptr=owner+1 (mod 4, wraps 3->0),
//     state=IDLE.
//   - timeout=1 for exactly that edge only if the release cause is the hold limit
//     AND done=0 AND req[owner]=1.
//   - Priority among release causes: done > request drop > timeout.
//     done in the limit cycle gives no timeout pulse.
//   - en=0 during GRANT does not revoke the grant; en is sampled only in IDLE.
//   - req changes on non-owner bits are ignored while in GRANT.
//  Back-to-back traffic:
//   - After every release there is exactly one IDLE cycle (gnt_valid=0) before the
//     next grant.
//   - A sustained request therefore owns at most MAX_HOLD cycles out of every
//     MAX_HOLD+1.
//  Fairness: with all 4 requesting continuously, grants rotate 0,1,2,3,0,...
//  done asserted in IDLE is ignored.
//  Width rules: hold_cnt is 8 bits; ptr and gnt_idx are IDX_W bits with natural
//   mod-4 wrap.
// STRUCTURE
//  Shared package arb_pkg:
//   - state enum {IDLE, GRANT}
//   - constants N=4 and IDX_W=2
//   - function onehot(idx)
//  Sub-module rr_priority_encoder: combinational block; inputs req[N-1:0] and
//   ptr[IDX_W-1:0]; outputs any and idx[IDX_W-1:0]. It rotates req by ptr, applies a
//   fixed-priority encode (lowest bit wins), then adds ptr mod 4.
//  Top level contains the FSM, ptr register, hold counter and output registers.
// TESTING
//  1 Reset: rst=1 with req=4'b1111 -> gnt=0, gnt_valid=0, timeout=0; release rst,
//    one edge later -> gnt=4'b0001, gnt_idx=0.
//  2 Rotation: req=4'b1111 held, done pulsed 1 cycle after each grant -> gnt_idx
//    sequence 0,1,2,3,0 with one gnt_valid=0 cycle between each grant.
//  3 Wrap: ptr=3 (after owner 2 released), req=4'b0101 -> grant to 0, gnt_idx=0;
//    then ptr=1, req=4'b0101 -> grant to 2.
//  4 Timeout: MAX_HOLD=8, req=4'b0010 held, done=0 -> gnt=4'b0010 for exactly 8
//    cycles, timeout=1 on the release edge, 1 idle cycle, then re-grant to 1.
//  5 Simultaneous: done=1 in the hold_cnt==MAX_HOLD-1 cycle -> release with
//    timeout=0. Owner drops req with en=0 -> release and no new grant while en=0.
//  6 Reset mid-grant: rst asserted asynchronously between edges while gnt=4'b0100 ->
//    gnt=0 without waiting for an edge; ptr=0 after reset is released.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin encoder arbiter.
// Purpose : requester count, index width, FSM state type and a one-hot helper
//           used by the arbiter top level and its priority encoder.
// Contents: N, IDX_W constants; state_t {IDLE, GRANT}; onehot(idx).
package arb_pkg;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Expands an encoded requester index into its one-hot grant vector.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating priority encoder.
// Purpose : picks the first set request bit scanning upward from ptr with wrap.
// Ports   : req [N-1:0]     request vector
//           ptr [IDX_W-1:0] index that currently has highest priority
//           any             at least one request is set
//           idx [IDX_W-1:0] winning requester index (meaningful when any=1)
module rr_priority_encoder
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0]   reqDbl;
  logic [N-1:0]     reqRot;
  logic [IDX_W-1:0] encRot;

  // Rotate so that bit 0 of reqRot is requester ptr, then take the lowest
  // set bit. The doubled copy of req provides the wrap-around for free.
  always_comb begin
    reqDbl = {req, req};
    reqRot = reqDbl[ptr +: N];
    encRot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        encRot = IDX_W'(i);
      end
    end
  end

  // Undo the rotation; the IDX_W-bit add wraps naturally mod N.
  assign any = |req;
  assign idx = encRot + ptr;

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with encoded grant index.
// Purpose : shares one downstream resource among N requesters, holds the grant
//           until release and forces release after MAX_HOLD cycles.
// Ports   : clk, rst (async, active-high)
//           en         new grants allowed (only looked at while idle)
//           req [N-1:0]  request vector
//           done       owner releases the resource
//           gnt [N-1:0]  one-hot grant, registered
//           gnt_idx    encoded owner index, registered
//           gnt_valid  grant active, registered
//           timeout    one-cycle pulse on a hold-limit release, registered
module rr_encoder_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             timeout_q;

  logic             winAny;
  logic [IDX_W-1:0] winIdx;
  logic             ownerReq;
  logic             holdLimit;
  logic             relNow;

  rr_priority_encoder u_enc (
    .req (req),
    .ptr (ptr_q),
    .any (winAny),
    .idx (winIdx)
  );

  // Release decision for the current owner. done has top priority, then a
  // dropped request, then the hold limit; only the last one raises timeout.
  always_comb begin
    hold_d    = hold_q + 8'd1;
    ptr_d     = idx_q + IDX_W'(1);
    ownerReq  = req[idx_q];
    holdLimit = (hold_q == HOLD_LAST);
    relNow    = done | ~ownerReq | holdLimit;
  end

  // FSM with registered outputs. A release always lands in IDLE for one
  // cycle, which is what gives the other requesters their turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en && winAny) begin
            state_q <= GRANT;
            gnt_q   <= onehot(winIdx);
            idx_q   <= winIdx;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          if (relNow) begin
            state_q   <= IDLE;
            ptr_q     <= ptr_d;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= holdLimit & ~done & ownerReq;
          end else begin
            hold_q <= hold_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule
